voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter VOICES, default 4, number of synthesis voices; legal range 2..16.
REQ-002 Parameter STEAL_OLDEST, default 1; 1 = steal the oldest voice when all are busy, 0 = drop the request.
REQ-003 clock_50_000_000  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_l  input  1  asynchronous, active-low reset.
REQ-005 note  input  note_change_t (MIDI package)  {status ON/OFF, note[6:0], velocity[6:0]}; valid only when note_ready=1.
REQ-006 note_ready  input  1  single-cycle strobe; one note event per high cycle; back-to-back cycles allowed.
REQ-007 pipeline_notes  output  note_change_t [VOICES-1:0]  registered per-voice note command.
REQ-008 pipeline_notes_ready  output  [VOICES-1:0]  one-cycle strobe per voice qualifying pipeline_notes[v].
REQ-009 voice_stolen  output  1  one-cycle pulse; an active voice was reassigned.
REQ-010 note_dropped  output  1  one-cycle pulse; ON request discarded (all busy, STEAL_OLDEST=0).

Function
REQ-011 Per-voice state shall be: active bit, note number (7 b), age (clog2(VOICES) b, saturating at VOICES-1).
REQ-012 An event sampled at rising edge N shall produce its outputs in the cycle after edge N (latency 1); no other cycle shows a strobe.
REQ-013 ON with velocity 0 shall be processed exactly as OFF with that note and velocity 0.
REQ-014 ON, note already active on voice k (retrigger): drive {ON,note,vel} on k, strobe only bit k, set age[k]=0, increment age of other active voices; no new voice is allocated.
REQ-015 ON, not active, a free voice exists: choose lowest-index free voice f; drive {ON,note,vel} on f, mark active, age[f]=0, increment other active ages.
REQ-016 ON, all voices busy, STEAL_OLDEST=1: choose voice with maximum age, ties to lowest index; overwrite with {ON,note,vel}, strobe that bit, pulse voice_stolen, age 0, increment others.
REQ-017 ON, all voices busy, STEAL_OLDEST=0: no state change, pipeline_notes_ready stays 0, pulse note_dropped.
REQ-018 OFF, note active on voice k: drive {OFF,note,vel} on k, strobe bit k, clear active[k]; ages of others unchanged.
REQ-019 OFF for a note not active on any voice: no output strobe, no state change, no pulse.
REQ-020 At most one bit of pipeline_notes_ready shall be high in any cycle.
REQ-021 pipeline_notes[v] shall hold its last value when not strobed; non-strobed entries never change.
REQ-022 Back-to-back events shall each see state updated by the preceding event.
REQ-023 A note number shall never be active on two voices simultaneously.

Reset
REQ-024 While reset_l=0: all voices inactive, ages 0, pipeline_notes all zero, pipeline_notes_ready=0, voice_stolen=0, note_dropped=0.
REQ-025 Reset asserted mid-operation shall clear state immediately, with no strobes; a note_ready pulse coincident with reset is ignored.
REQ-026 First event accepted at the first rising edge with reset_l=1.

Verification (VOICES=4)
REQ-027 Reset; ON(10,20) -> next cycle ready=4'b0001, notes[0]={ON,10,20}; OFF(10,123) -> ready=4'b0001, notes[0]={OFF,10,123}.
REQ-028 ON 10,20,30,40 -> voices 0..3 in order; ON(50,100), STEAL_OLDEST=1 -> ready=4'b0001, notes[0]={ON,50,100}, voice_stolen=1; OFF(10) -> no strobe.
REQ-029 Same sequence, STEAL_OLDEST=0 -> ON(50) gives ready=0, note_dropped=1; OFF(50,100) -> no effect; OFF 10..40 free voices 0..3.
REQ-030 ON10, ON20, OFF20, ON40 -> ON40 on voice 1; ON(40,80) again -> ready=4'b0010 only, velocity 80, no second voice.
REQ-031 ON(30,60) then ON(30,0) on consecutive cycles -> voice 0 strobes {ON,30,60} then {OFF,30,0} in consecutive cycles; voice 0 free afterward.
REQ-032 Four voices active, reset_l pulsed low one cycle -> all outputs 0; ON(60,120) -> voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note on/off events onto a fixed pool
// of synthesis voices, with retrigger, lowest-free allocation and
// oldest-voice stealing (or dropping) when the pool is exhausted.

package midi_pkg;

    // One note command as seen by a voice; status 1 = ON, 0 = OFF.
    typedef struct packed {
        logic       status;
        logic [6:0] note;
        logic [6:0] velocity;
    } note_change_t;

endpackage : midi_pkg

module voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned VOICES       = 4,
    parameter int unsigned STEAL_OLDEST = 1
) (
    input  logic                             clock_50_000_000,
    input  logic                             reset_l,
    input  note_change_t                     note,
    input  logic                             note_ready,
    output note_change_t [VOICES-1:0]        pipeline_notes,
    output logic         [VOICES-1:0]        pipeline_notes_ready,
    output logic                             voice_stolen,
    output logic                             note_dropped
);

    localparam int unsigned AW      = $clog2(VOICES);
    localparam logic [AW-1:0] AGE_MAX = AW'(VOICES - 1);

    // Per-voice allocation state
    logic [VOICES-1:0]          active_q, active_d;
    logic [VOICES-1:0][6:0]     vnote_q,  vnote_d;
    logic [VOICES-1:0][AW-1:0]  age_q,    age_d;

    // Registered outputs
    note_change_t [VOICES-1:0]  notes_q,   notes_d;
    logic [VOICES-1:0]          ready_q,   ready_d;
    logic                       stolen_q,  stolen_d;
    logic                       dropped_q, dropped_d;

    // Lookup results
    logic                       hit;
    int unsigned                hit_idx;
    logic                       free_found;
    int unsigned                free_idx;
    int unsigned                old_idx;
    logic [AW-1:0]              old_age;

    logic                       is_on;
    logic                       alloc;
    int unsigned                tgt;

    // Search the pool: voice holding this note, lowest free voice, oldest voice
    always_comb begin
        hit        = 1'b0;
        hit_idx    = 0;
        free_found = 1'b0;
        free_idx   = 0;
        old_idx    = 0;
        old_age    = age_q[0];
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (!hit && active_q[v] && (vnote_q[v] == note.note)) begin
                hit     = 1'b1;
                hit_idx = v;
            end
            if (!free_found && !active_q[v]) begin
                free_found = 1'b1;
                free_idx   = v;
            end
            // Strict compare keeps the lowest index on ties
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_idx = v;
            end
        end
    end

    // Next-state and next-output computation for one event
    always_comb begin
        active_d  = active_q;
        vnote_d   = vnote_q;
        age_d     = age_q;
        notes_d   = notes_q;
        ready_d   = '0;
        stolen_d  = 1'b0;
        dropped_d = 1'b0;
        alloc     = 1'b0;
        tgt       = 0;
        // ON with zero velocity is treated as OFF
        is_on     = note.status && (note.velocity != 7'd0);

        if (note_ready) begin
            if (is_on) begin
                if (hit) begin
                    alloc = 1'b1;
                    tgt   = hit_idx;
                end else if (free_found) begin
                    alloc = 1'b1;
                    tgt   = free_idx;
                end else if (STEAL_OLDEST != 0) begin
                    alloc    = 1'b1;
                    tgt      = old_idx;
                    stolen_d = 1'b1;
                end else begin
                    dropped_d = 1'b1;
                end

                if (alloc) begin
                    for (int unsigned v = 0; v < VOICES; v++) begin
                        if (v == tgt) begin
                            active_d[v]         = 1'b1;
                            vnote_d[v]          = note.note;
                            age_d[v]            = '0;
                            notes_d[v].status   = 1'b1;
                            notes_d[v].note     = note.note;
                            notes_d[v].velocity = note.velocity;
                            ready_d[v]          = 1'b1;
                        end else if (active_q[v] && (age_q[v] != AGE_MAX)) begin
                            age_d[v] = age_q[v] + AW'(1);
                        end
                    end
                end
            end else if (hit) begin
                for (int unsigned v = 0; v < VOICES; v++) begin
                    if (v == hit_idx) begin
                        active_d[v]         = 1'b0;
                        notes_d[v].status   = 1'b0;
                        notes_d[v].note     = note.note;
                        notes_d[v].velocity = note.velocity;
                        ready_d[v]          = 1'b1;
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            active_q  <= '0;
            vnote_q   <= '0;
            age_q     <= '0;
            notes_q   <= '0;
            ready_q   <= '0;
            stolen_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            vnote_q   <= vnote_d;
            age_q     <= age_d;
            notes_q   <= notes_d;
            ready_q   <= ready_d;
            stolen_q  <= stolen_d;
            dropped_q <= dropped_d;
        end
    end

    assign pipeline_notes       = notes_q;
    assign pipeline_notes_ready = ready_q;
    assign voice_stolen         = stolen_q;
    assign note_dropped         = dropped_q;

endmodule : voice_allocator

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: instance A steals, instance B drops.
module tb_voice_allocator;
    import midi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    note_change_t              note_a, note_b;
    logic                      nr_a, nr_b;
    note_change_t [3:0]        pn_a, pn_b;
    logic [3:0]                pr_a, pr_b;
    logic                      st_a, st_b, dr_a, dr_b;

    voice_allocator #(.VOICES(4), .STEAL_OLDEST(1)) u_a (
        .clock_50_000_000     (clk),
        .reset_l              (rst_n),
        .note                 (note_a),
        .note_ready           (nr_a),
        .pipeline_notes       (pn_a),
        .pipeline_notes_ready (pr_a),
        .voice_stolen         (st_a),
        .note_dropped         (dr_a)
    );

    voice_allocator #(.VOICES(4), .STEAL_OLDEST(0)) u_b (
        .clock_50_000_000     (clk),
        .reset_l              (rst_n),
        .note                 (note_b),
        .note_ready           (nr_b),
        .pipeline_notes       (pn_b),
        .pipeline_notes_ready (pr_b),
        .voice_stolen         (st_b),
        .note_dropped         (dr_b)
    );

    typedef struct {
        int unsigned  cyc;
        logic [3:0]   ready;
        int           v;
        note_change_t pay;
        bit           stolen;
        bit           dropped;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    note_change_t [3:0] sh_a = '0;
    note_change_t [3:0] sh_b = '0;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %h want %h (t=%0t)", name, d, act, exp, $time);
    endtask

    // Issue one event on DUT d and record the response expected one cycle later.
    // v < 0 means no voice strobe.
    task automatic ev(input int d, input bit on, input int n, input int vel,
                      input int v, input bit out_on, input bit st, input bit dr);
        note_change_t nc;
        exp_t e;
        nc.status   = on;
        nc.note     = 7'(n);
        nc.velocity = 7'(vel);
        e.cyc          = cyc + 1;
        e.ready        = (v >= 0) ? 4'(1 << v) : 4'b0000;
        e.v            = v;
        e.pay.status   = out_on;
        e.pay.note     = nc.note;
        e.pay.velocity = nc.velocity;
        e.stolen       = st;
        e.dropped      = dr;
        if (v >= 0 || dr || st) begin
            if (d == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        if (d == 0) begin note_a = nc; nr_a = 1'b1; end
        else        begin note_b = nc; nr_b = 1'b1; end
        @(posedge clk); #1;
        nr_a = 1'b0;
        nr_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: compares whatever DUT d presents against the scoreboard
    task automatic mon(input int d);
        logic [3:0]         r;
        logic               s, dd;
        note_change_t [3:0] pn;
        exp_t               e;
        bit                 have;
        r  = (d == 0) ? pr_a : pr_b;
        s  = (d == 0) ? st_a : st_b;
        dd = (d == 0) ? dr_a : dr_b;
        pn = (d == 0) ? pn_a : pn_b;
        if (!rst_n) begin
            chk("rst_ready",   d, 64'(r),  64'd0);
            chk("rst_stolen",  d, 64'(s),  64'd0);
            chk("rst_dropped", d, 64'(dd), 64'd0);
            chk("rst_notes",   d, 64'(pn), 64'd0);
            if (d == 0) sh_a = '0; else sh_b = '0;
        end else if (r != 4'b0000 || s || dd) begin
            have = 1'b0;
            if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++;
                $display("FAIL unexpected_output dut%0d: got ready=%b stolen=%b dropped=%b want none (t=%0t)",
                         d, r, s, dd, $time);
            end else begin
                chk("latency", d, 64'(cyc),     64'(e.cyc));
                chk("ready",   d, 64'(r),       64'(e.ready));
                chk("stolen",  d, 64'(s),       64'(e.stolen));
                chk("dropped", d, 64'(dd),      64'(e.dropped));
                if (e.v >= 0) begin
                    if (d == 0) sh_a[e.v] = e.pay; else sh_b[e.v] = e.pay;
                end
                chk("notes", d, 64'(pn), (d == 0) ? 64'(sh_a) : 64'(sh_b));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        note_a = '0; note_b = '0; nr_a = 1'b0; nr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic on/off
        ev(0, 1, 10, 20,  0, 1, 0, 0);
        ev(0, 0, 10, 123, 0, 0, 0, 0);
        // Fill pool, then steal oldest
        ev(0, 1, 10, 11, 0, 1, 0, 0);
        ev(0, 1, 20, 11, 1, 1, 0, 0);
        ev(0, 1, 30, 11, 2, 1, 0, 0);
        ev(0, 1, 40, 11, 3, 1, 0, 0);
        ev(0, 1, 50, 100, 0, 1, 1, 0);
        ev(0, 0, 10, 0,  -1, 0, 0, 0);
        ev(0, 1, 60, 5,   1, 1, 1, 0);
        ev(0, 0, 50, 1, 0, 0, 0, 0);
        ev(0, 0, 60, 1, 1, 0, 0, 0);
        ev(0, 0, 30, 1, 2, 0, 0, 0);
        ev(0, 0, 40, 1, 3, 0, 0, 0);
        // Reuse of freed voice and retrigger
        ev(0, 1, 10, 1,  0, 1, 0, 0);
        ev(0, 1, 20, 1,  1, 1, 0, 0);
        ev(0, 0, 20, 1,  1, 0, 0, 0);
        ev(0, 1, 40, 70, 1, 1, 0, 0);
        ev(0, 1, 40, 80, 1, 1, 0, 0);
        ev(0, 0, 10, 1,  0, 0, 0, 0);
        ev(0, 0, 40, 1,  1, 0, 0, 0);
        // ON then ON-velocity-0 back to back
        ev(0, 1, 30, 60, 0, 1, 0, 0);
        ev(0, 1, 30, 0,  0, 0, 0, 0);
        ev(0, 1, 33, 1,  0, 1, 0, 0);
        ev(0, 0, 33, 2,  0, 0, 0, 0);
        idle(1);
        // Saturated ages tie: lowest index stolen first
        ev(0, 1, 1, 1, 0, 1, 0, 0);
        ev(0, 1, 2, 1, 1, 1, 0, 0);
        ev(0, 1, 3, 1, 2, 1, 0, 0);
        ev(0, 1, 4, 1, 3, 1, 0, 0);
        ev(0, 1, 4, 9, 3, 1, 0, 0);
        ev(0, 1, 5, 5, 0, 1, 1, 0);
        ev(0, 1, 6, 6, 1, 1, 1, 0);

        // Drop variant
        ev(1, 1, 10, 11, 0, 1, 0, 0);
        ev(1, 1, 20, 11, 1, 1, 0, 0);
        ev(1, 1, 30, 11, 2, 1, 0, 0);
        ev(1, 1, 40, 11, 3, 1, 0, 0);
        ev(1, 1, 50, 100, -1, 1, 0, 1);
        ev(1, 0, 50, 100, -1, 0, 0, 0);
        ev(1, 0, 10, 1, 0, 0, 0, 0);
        ev(1, 0, 20, 1, 1, 0, 0, 0);
        ev(1, 0, 30, 1, 2, 0, 0, 0);
        ev(1, 0, 40, 1, 3, 0, 0, 0);
        ev(1, 1, 77, 1, 0, 1, 0, 0);
        idle(2);

        // One-cycle reset pulse with a coincident event that must be ignored
        rst_n  = 1'b0;
        note_a = '{status: 1'b1, note: 7'd70, velocity: 7'd70};
        nr_a   = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nr_a  = 1'b0;
        ev(0, 1, 60, 120, 0, 1, 0, 0);
        ev(1, 1, 61, 1,   0, 1, 0, 0);
        idle(3);

        chk("queue_empty", 0, 64'(q_a.size()), 64'd0);
        chk("queue_empty", 1, 64'(q_b.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_voice_allocator
